// File: rtl/multi_score_tracker.sv
// Multi-player whack-a-mole score engine: saturating scores with combo bonus and
// miss penalty, plus an end-of-game leader/tie scan and a persistent high score.
module multi_score_tracker #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  parameter int COMBO_LEN   = 3,
  parameter int BONUS       = 2,
  parameter int PENALTY     = 1,
  localparam int LW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clkIn,
  input  logic                           reset,
  input  logic                           game_active,
  input  logic [NUM_PLAYERS-1:0]         hit,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [SCORE_W-1:0]             high_score,
  output logic [LW-1:0]                  leader,
  output logic                           tie,
  output logic                           results_valid,
  output logic                           new_high
);

  // state   | meaning
  // IDLE    | scores held for display, waiting for game_active
  // PLAYING | per-player hit/miss scoring
  // SCAN    | one player per cycle, tracking max/leader/tie
  // DONE    | high-score update, results_valid raised
  typedef enum logic [1:0] {IDLE, PLAYING, SCAN, DONE} state_t;

  localparam int SKW = $clog2(COMBO_LEN + 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = '1;
  localparam logic [31:0] MAX32 = 32'(MAX_SCORE);
  localparam logic [SKW-1:0] COMBO_CNT = SKW'(COMBO_LEN);
  localparam logic [LW-1:0] LAST_IDX = LW'(NUM_PLAYERS - 1);

  state_t state, state_nxt;

  logic [SCORE_W-1:0] score_r    [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_nxt  [NUM_PLAYERS];
  logic [SKW-1:0]     streak_r   [NUM_PLAYERS];
  logic [SKW-1:0]     streak_nxt [NUM_PLAYERS];
  logic [LW-1:0]      idx;
  logic [SCORE_W-1:0] max_score;
  logic [SCORE_W-1:0] cur_score;

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (game_active)  state_nxt = PLAYING;
      PLAYING: if (!game_active) state_nxt = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hit wins over a simultaneous miss; sums are formed wide so saturation never wraps.
  always_comb begin
    logic [31:0]    sum;
    logic [SKW-1:0] streak_inc;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      score_nxt[p]  = score_r[p];
      streak_nxt[p] = streak_r[p];
      sum           = '0;
      streak_inc    = streak_r[p] + SKW'(1);
      if (hit[p]) begin
        if (streak_inc == COMBO_CNT) begin
          sum           = 32'(score_r[p]) + 32'(1 + BONUS);
          streak_nxt[p] = '0;
        end else begin
          sum           = 32'(score_r[p]) + 32'd1;
          streak_nxt[p] = streak_inc;
        end
        score_nxt[p] = (sum > MAX32) ? MAX_SCORE : sum[SCORE_W-1:0];
      end else if (miss[p]) begin
        streak_nxt[p] = '0;
        if (32'(score_r[p]) >= 32'(PENALTY))
          score_nxt[p] = SCORE_W'(32'(score_r[p]) - 32'(PENALTY));
        else
          score_nxt[p] = '0;
      end
    end
  end

  assign cur_score = score_r[idx];

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        score_r[p]  <= '0;
        streak_r[p] <= '0;
      end
      idx           <= '0;
      max_score     <= '0;
      leader        <= '0;
      tie           <= 1'b0;
      high_score    <= '0;
      results_valid <= 1'b0;
      new_high      <= 1'b0;
    end else begin
      new_high <= 1'b0;
      case (state)
        IDLE: begin
          if (game_active) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              score_r[p]  <= '0;
              streak_r[p] <= '0;
            end
            results_valid <= 1'b0;
          end
        end
        PLAYING: begin
          if (game_active) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              score_r[p]  <= score_nxt[p];
              streak_r[p] <= streak_nxt[p];
            end
          end else begin
            idx       <= '0;
            max_score <= '0;
            leader    <= '0;
            tie       <= 1'b0;
          end
        end
        SCAN: begin
          // Strict > keeps the lowest index as leader when scores are equal.
          if (cur_score > max_score) begin
            max_score <= cur_score;
            leader    <= idx;
            tie       <= 1'b0;
          end else if (cur_score == max_score && idx != '0) begin
            tie <= 1'b1;
          end
          if (idx != LAST_IDX) idx <= idx + LW'(1);
        end
        DONE: begin
          if (max_score > high_score) begin
            high_score <= max_score;
            new_high   <= 1'b1;
          end
          results_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      score[p*SCORE_W +: SCORE_W] = score_r[p];
  end

endmodule

// File: tb/tb_multi_score_tracker.sv
// Directed bench for multi_score_tracker: an 8-bit instance for scoring/scan/reset
// and a 4-bit instance for saturation, sharing game_active and reset.
module tb_multi_score_tracker;

  logic clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  logic        reset, game_active;
  logic [1:0]  hit, miss, hit_s, miss_s;
  logic [15:0] score;
  logic [7:0]  high_score;
  logic [0:0]  leader;
  logic        tie, results_valid, new_high;
  logic [7:0]  score_s;
  logic [3:0]  high_s;
  logic [0:0]  leader_s;
  logic        tie_s, rv_s, new_high_s;

  int tests = 0;
  int fails = 0;

  multi_score_tracker #(.NUM_PLAYERS(2), .SCORE_W(8)) dut (
    .clkIn(clkIn), .reset(reset), .game_active(game_active), .hit(hit), .miss(miss),
    .score(score), .high_score(high_score), .leader(leader), .tie(tie),
    .results_valid(results_valid), .new_high(new_high)
  );

  multi_score_tracker #(.NUM_PLAYERS(2), .SCORE_W(4)) dut_sat (
    .clkIn(clkIn), .reset(reset), .game_active(game_active), .hit(hit_s), .miss(miss_s),
    .score(score_s), .high_score(high_s), .leader(leader_s), .tie(tie_s),
    .results_valid(rv_s), .new_high(new_high_s)
  );

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [1:0] h, input logic [1:0] m);
    hit = h; miss = m;
    tick();
    hit = '0; miss = '0;
  endtask

  task automatic pulse_s(input logic [1:0] h, input logic [1:0] m);
    hit_s = h; miss_s = m;
    tick();
    hit_s = '0; miss_s = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; game_active = 1'b0;
    hit = '0; miss = '0; hit_s = '0; miss_s = '0;
    repeat (2) tick();
    check("rst_score", 32'(score), 0);
    check("rst_high", 32'(high_score), 0);
    check("rst_leader", 32'(leader), 0);
    check("rst_tie", 32'(tie), 0);
    check("rst_valid", 32'(results_valid), 0);
    check("rst_new_high", 32'(new_high), 0);
    reset = 1'b1;
    tick();
    pulse(2'b11, 2'b00);
    pulse(2'b11, 2'b00);
    check("idle_hits_ignored", 32'(score), 0);

    // game 1
    game_active = 1'b1;
    tick();
    pulse(2'b01, 2'b00); check("p0_hit1", 32'(score[7:0]), 1);
    pulse(2'b01, 2'b00); check("p0_hit2", 32'(score[7:0]), 2);
    pulse(2'b01, 2'b00); check("p0_combo", 32'(score[7:0]), 5);
    pulse(2'b01, 2'b00); check("p0_hit4", 32'(score[7:0]), 6);
    pulse(2'b00, 2'b01); check("p0_miss", 32'(score[7:0]), 5);
    pulse(2'b01, 2'b00); check("p0_after_miss1", 32'(score[7:0]), 6);
    pulse(2'b01, 2'b00); check("p0_after_miss2", 32'(score[7:0]), 7);
    pulse(2'b01, 2'b00); check("p0_combo2", 32'(score[7:0]), 10);

    pulse(2'b00, 2'b10); check("p1_miss_floor", 32'(score[15:8]), 0);
    repeat (3) pulse(2'b10, 2'b00);
    check("p1_combo", 32'(score[15:8]), 5);
    pulse(2'b00, 2'b10); check("p1_miss", 32'(score[15:8]), 4);
    pulse(2'b10, 2'b10); check("p1_hit_and_miss", 32'(score[15:8]), 5);
    check("p0_untouched", 32'(score[7:0]), 10);

    repeat (9) pulse_s(2'b01, 2'b00);
    check("sat_exact_max", 32'(score_s[3:0]), 15);
    repeat (3) pulse_s(2'b00, 2'b01);
    check("sat_misses", 32'(score_s[3:0]), 12);
    repeat (2) pulse_s(2'b01, 2'b00);
    check("sat_at_14", 32'(score_s[3:0]), 14);
    pulse_s(2'b01, 2'b00);
    check("sat_combo_clamp", 32'(score_s[3:0]), 15);
    repeat (3) pulse_s(2'b01, 2'b00);
    check("sat_hold", 32'(score_s[3:0]), 15);

    repeat (3) pulse(2'b00, 2'b01);
    check("p0_final", 32'(score[7:0]), 7);
    pulse(2'b10, 2'b00);
    pulse(2'b10, 2'b00);
    check("p1_final", 32'(score[15:8]), 9);

    hit = 2'b01; game_active = 1'b0;
    tick();
    hit = '0;
    check("end_pulse_ignored", 32'(score[7:0]), 7);
    tick();
    tick();
    check("scan_valid_low", 32'(results_valid), 0);
    check("scan_new_high_low", 32'(new_high), 0);
    tick();
    check("g1_leader", 32'(leader), 1);
    check("g1_tie", 32'(tie), 0);
    check("g1_high", 32'(high_score), 9);
    check("g1_new_high", 32'(new_high), 1);
    check("g1_valid", 32'(results_valid), 1);
    check("sat_high", 32'(high_s), 15);
    check("sat_leader", 32'(leader_s), 0);
    check("sat_tie", 32'(tie_s), 0);
    tick();
    check("g1_new_high_1cyc", 32'(new_high), 0);
    check("g1_valid_holds", 32'(results_valid), 1);
    check("idle_score_hold", 32'(score[7:0]), 7);

    // game 2: 9/9 tie, game_active raised during SCAN
    game_active = 1'b1;
    tick();
    check("g2_valid_cleared", 32'(results_valid), 0);
    check("g2_scores_cleared", 32'(score), 0);
    check("g2_leader_holds", 32'(leader), 1);
    repeat (6) pulse(2'b11, 2'b00);
    pulse(2'b00, 2'b11);
    check("g2_p0", 32'(score[7:0]), 9);
    check("g2_p1", 32'(score[15:8]), 9);
    game_active = 1'b0;
    tick();
    game_active = 1'b1;
    tick();
    tick();
    tick();
    check("g2_tie", 32'(tie), 1);
    check("g2_leader", 32'(leader), 0);
    check("g2_high_stays", 32'(high_score), 9);
    check("g2_no_new_high", 32'(new_high), 0);
    check("g2_valid", 32'(results_valid), 1);
    check("sat_zero_tie", 32'(tie_s), 1);
    check("sat_high_stays", 32'(high_s), 15);
    tick();
    check("g3_started", 32'(results_valid), 0);
    check("g3_scores_cleared", 32'(score), 0);

    // game 3: reset in the middle of the scan
    repeat (3) pulse(2'b01, 2'b00);
    check("g3_p0", 32'(score[7:0]), 5);
    game_active = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_high", 32'(high_score), 0);
    check("mid_rst_leader", 32'(leader), 0);
    check("mid_rst_tie", 32'(tie), 0);
    check("mid_rst_valid", 32'(results_valid), 0);
    check("mid_rst_sat_high", 32'(high_s), 0);
    reset = 1'b1;
    repeat (4) tick();
    check("post_rst_idle_valid", 32'(results_valid), 0);
    check("post_rst_idle_high", 32'(high_score), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
